// File: rtl/vga_color_select_if.sv
// Button inputs and colour outputs of the VGA colour selector.
// master = button/board side, slave = vga_color_select.
interface vga_color_select_if;
    logic        BTN_NEXT;
    logic        BTN_PREV;
    logic [3:0]  color_idx;
    logic [11:0] rgb;
    logic        changed;

    modport master (
        output BTN_NEXT,
        output BTN_PREV,
        input  color_idx,
        input  rgb,
        input  changed
    );

    modport slave (
        input  BTN_NEXT,
        input  BTN_PREV,
        output color_idx,
        output rgb,
        output changed
    );
endinterface

// File: rtl/vga_color_select.sv
// Debounced NEXT/PREV buttons step a palette index and emit a registered 12-bit colour.
// Optional auto-repeat while one button is held: define VGA_COLOR_AUTO_REPEAT_EN.
module vga_color_select #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NCOLORS         = 8,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic               CLK50MHZ,
    input  logic               RST,
    vga_color_select_if.slave  bus
);
    localparam int             DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]     IDX_MAX = 4'(NCOLORS - 1);

    function automatic logic [11:0] palette(input logic [3:0] i);
        case (i)
            4'd0:    palette = 12'h000;
            4'd1:    palette = 12'hF00;
            4'd2:    palette = 12'h0F0;
            4'd3:    palette = 12'h00F;
            4'd4:    palette = 12'hFF0;
            4'd5:    palette = 12'h0FF;
            4'd6:    palette = 12'hF0F;
            4'd7:    palette = 12'hFFF;
            4'd8:    palette = 12'h777;
            4'd9:    palette = 12'h700;
            4'd10:   palette = 12'h070;
            4'd11:   palette = 12'h007;
            4'd12:   palette = 12'h770;
            4'd13:   palette = 12'h077;
            4'd14:   palette = 12'h707;
            4'd15:   palette = 12'h333;
            default: palette = 12'h000;
        endcase
    endfunction

    // Bit 0 tracks BTN_NEXT, bit 1 tracks BTN_PREV.
    logic [1:0]    sync1_r, sync2_r, stable_r, stable_d_r, press_r;
    logic [DW-1:0] cnt_r [2];
    logic [1:0]    rep_fire_s;
    logic [3:0]    idx_r, idx_nxt_s;
    logic [11:0]   rgb_r;
    logic          changed_r, step_s;

    // Synchroniser, per-button debounce and the registered press pulse.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            sync1_r    <= 2'b00;
            sync2_r    <= 2'b00;
            stable_r   <= 2'b00;
            stable_d_r <= 2'b00;
            press_r    <= 2'b00;
            cnt_r[0]   <= DW'(0);
            cnt_r[1]   <= DW'(0);
        end else begin
            sync1_r    <= {bus.BTN_PREV, bus.BTN_NEXT};
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= (stable_r & ~stable_d_r) | rep_fire_s;
            for (int b = 0; b < 2; b++) begin
                if (sync2_r[b] == stable_r[b]) begin
                    cnt_r[b] <= DW'(0);
                end else if (cnt_r[b] == DB_LAST) begin
                    stable_r[b] <= sync2_r[b];
                    cnt_r[b]    <= DW'(0);
                end else begin
                    cnt_r[b] <= cnt_r[b] + DW'(1);
                end
            end
        end
    end

`ifdef VGA_COLOR_AUTO_REPEAT_EN
    localparam int            RW       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_r;
    logic          hold_next_s, hold_prev_s, rep_wrap_s;

    // Exactly one button held past its press cycle; the count aligns repeats to the press step.
    always_comb begin
        hold_next_s = stable_r[0] & stable_d_r[0] & ~stable_r[1];
        hold_prev_s = stable_r[1] & stable_d_r[1] & ~stable_r[0];
        rep_wrap_s  = (rep_cnt_r == REP_LAST);
        if ((hold_next_s | hold_prev_s) && rep_wrap_s) begin
            rep_fire_s = {hold_prev_s, hold_next_s};
        end else begin
            rep_fire_s = 2'b00;
        end
    end

    // Repeat interval counter; clears on release, on both held, and on each repeat.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            rep_cnt_r <= RW'(0);
        end else if ((hold_next_s | hold_prev_s) && !rep_wrap_s) begin
            rep_cnt_r <= rep_cnt_r + RW'(1);
        end else begin
            rep_cnt_r <= RW'(0);
        end
    end
`else
    // Repeat path compiled out; the parameter stays so instantiations match across builds.
    assign rep_fire_s = (REPEAT_CYCLES > 0) ? 2'b00 : 2'b00;
`endif

    // Wrap-around step; simultaneous NEXT and PREV cancel out.
    always_comb begin
        idx_nxt_s = idx_r;
        step_s    = 1'b0;
        case (press_r)
            2'b01: begin
                idx_nxt_s = (idx_r == IDX_MAX) ? 4'd0 : idx_r + 4'd1;
                step_s    = 1'b1;
            end
            2'b10: begin
                idx_nxt_s = (idx_r == 4'd0) ? IDX_MAX : idx_r - 4'd1;
                step_s    = 1'b1;
            end
            default: begin
                idx_nxt_s = idx_r;
                step_s    = 1'b0;
            end
        endcase
    end

    // Output registers: index, its palette colour and the change strobe update together.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            idx_r     <= 4'd0;
            rgb_r     <= 12'h000;
            changed_r <= 1'b0;
        end else begin
            idx_r     <= idx_nxt_s;
            rgb_r     <= palette(idx_nxt_s);
            changed_r <= step_s;
        end
    end

    assign bus.color_idx = idx_r;
    assign bus.rgb       = rgb_r;
    assign bus.changed   = changed_r;
endmodule

// File: tb/tb_vga_color_select.sv
// Self-checking bench for vga_color_select: two instances (8 and 16 colours) share
// the buttons and are compared every cycle against a press-schedule reference model.
module tb_vga_color_select;
    localparam int D = 4;
    localparam int R = 20;

    logic clk = 1'b0;
    logic rst;
    logic btn_next, btn_prev;

    always #10 clk = ~clk;

    vga_color_select_if bus8 ();
    vga_color_select_if bus16 ();

    assign bus8.BTN_NEXT  = btn_next;
    assign bus8.BTN_PREV  = btn_prev;
    assign bus16.BTN_NEXT = btn_next;
    assign bus16.BTN_PREV = btn_prev;

    vga_color_select #(.DEBOUNCE_CYCLES(D), .NCOLORS(8), .REPEAT_CYCLES(R)) dut8 (
        .CLK50MHZ (clk),
        .RST      (rst),
        .bus      (bus8.slave)
    );

    vga_color_select #(.DEBOUNCE_CYCLES(D), .NCOLORS(16), .REPEAT_CYCLES(R)) dut16 (
        .CLK50MHZ (clk),
        .RST      (rst),
        .bus      (bus16.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          exp8     = 0;
    int          exp16    = 0;
    logic        exp_chg  = 1'b0;
    int          sched_t[$];
    int          sched_d[$];
    logic [11:0] pal [16];

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge: advance the model, then compare both DUTs just after the edge.
    task automatic tick();
        int d;
        @(posedge clk);
        cyc++;
        exp_chg = 1'b0;
        if (rst) begin
            exp8  = 0;
            exp16 = 0;
            sched_t.delete();
            sched_d.delete();
        end else begin
            while (sched_t.size() > 0 && sched_t[0] == cyc) begin
                void'(sched_t.pop_front());
                d       = sched_d.pop_front();
                exp8    = (exp8 + d + 8) % 8;
                exp16   = (exp16 + d + 16) % 16;
                exp_chg = 1'b1;
            end
        end
        #1;
        check("idx8",  {8'h00, bus8.color_idx},  12'(exp8));
        check("rgb8",  bus8.rgb,                 pal[exp8]);
        check("chg8",  {11'h000, bus8.changed},  {11'h000, exp_chg});
        check("idx16", {8'h00, bus16.color_idx}, 12'(exp16));
        check("rgb16", bus16.rgb,                pal[exp16]);
        check("chg16", {11'h000, bus16.changed}, {11'h000, exp_chg});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // A clean button level first sampled at edge k steps the index at edge k+D+3.
    task automatic schedule(input int k, input int dir);
        sched_t.push_back(k + D + 3);
        sched_d.push_back(dir);
    endtask

    // mask: 1 = NEXT, 2 = PREV, 3 = both on the same edge (no step).
    task automatic press(input int mask, input int hold, input int gap);
        int k;
        k = cyc + 1;
        btn_next = mask[0];
        btn_prev = mask[1];
        if (mask == 1) schedule(k, 1);
        else if (mask == 2) schedule(k, -1);
        ticks(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        ticks(gap);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        ticks(n);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int mask;
        pal[0]  = 12'h000; pal[1]  = 12'hF00; pal[2]  = 12'h0F0; pal[3]  = 12'h00F;
        pal[4]  = 12'hFF0; pal[5]  = 12'h0FF; pal[6]  = 12'hF0F; pal[7]  = 12'hFFF;
        pal[8]  = 12'h777; pal[9]  = 12'h700; pal[10] = 12'h070; pal[11] = 12'h007;
        pal[12] = 12'h770; pal[13] = 12'h077; pal[14] = 12'h707; pal[15] = 12'h333;
        btn_next = 1'b0;
        btn_prev = 1'b0;

        // Reset for three edges, then a long idle stretch with no change.
        do_reset(3);
        ticks(50);
        check("idle_idx8", {8'h00, bus8.color_idx}, 12'h000);

        // Eight NEXT presses: climb to 7 then wrap to 0.
        for (int i = 0; i < 7; i++) press(1, 6, 8);
        check("next7_idx8", {8'h00, bus8.color_idx}, 12'h007);
        check("next7_rgb8", bus8.rgb, 12'hFFF);
        press(1, 6, 8);
        check("wrap_idx8", {8'h00, bus8.color_idx}, 12'h000);
        check("wrap_rgb8", bus8.rgb, 12'h000);

        // PREV from 0 wraps to the last entry of each palette size.
        do_reset(2);
        press(2, 6, 8);
        check("prev_idx8",  {8'h00, bus8.color_idx},  12'h007);
        check("prev_rgb8",  bus8.rgb,                 12'hFFF);
        check("prev_idx16", {8'h00, bus16.color_idx}, 12'h00F);
        check("prev_rgb16", bus16.rgb,                12'h333);

        // Bouncing NEXT (2-cycle runs) then steady: one step, timed from the final rise.
        for (int i = 0; i < 2; i++) begin
            btn_next = 1'b1; ticks(2);
            btn_next = 1'b0; ticks(2);
        end
        press(1, 12, 10);

        // Both buttons rising on the same edge: no step at all.
        press(3, 12, 10);

        // Reset mid-debounce with NEXT still held: full re-qualification after reset.
        btn_next = 1'b1;
        ticks(2);
        do_reset(2);
        k = cyc + 1;
        schedule(k, 1);
        ticks(12);
        btn_next = 1'b0;
        ticks(10);
        check("rst_held_idx8", {8'h00, bus8.color_idx}, 12'h001);

        // Long hold: auto-repeat steps every R cycles only when the feature is built in.
        do_reset(2);
        k = cyc + 1;
        btn_next = 1'b1;
        schedule(k, 1);
`ifdef VGA_COLOR_AUTO_REPEAT_EN
        for (int n = 1; n <= 3; n++) begin
            sched_t.push_back(k + D + 3 + n * R);
            sched_d.push_back(1);
        end
`endif
        ticks(70);
        btn_next = 1'b0;
        ticks(15);
`ifdef VGA_COLOR_AUTO_REPEAT_EN
        check("hold_idx8", {8'h00, bus8.color_idx}, 12'h004);
`else
        check("hold_idx8", {8'h00, bus8.color_idx}, 12'h001);
`endif

        // Randomised presses: NEXT, PREV or both, random hold and gap lengths.
        for (int i = 0; i < 30; i++) begin
            mask = int'($urandom_range(3, 1));
            press(mask, int'($urandom_range(14, 6)), int'($urandom_range(15, 8)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_color_select.md
Name: vga_color_select

Overview:
- Upstream stage of the VGA pixel path. It takes the raw BTN_NEXT/BTN_PREV board buttons, synchronises and debounces them, and steps a palette index.
- It presents a registered 12-bit RGB colour, which the VGA timing/pixel stage drives onto VGA_R/G/B during active video.
- All logic runs in the 50 MHz board clock domain.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a new button level (10 ms at 50 MHz); legal range 2..2^20.
- NCOLORS, 8, number of palette entries in use; legal range 2..16; the index wraps within 0..NCOLORS-1.
- REPEAT_CYCLES, 25000000, hold time between auto-repeat steps (used only with VGA_COLOR_AUTO_REPEAT_EN).

Ports:
- CLK50MHZ  input  1  board clock, 50 MHz; all state changes on its rising edge.
- RST  input  1  reset; synchronous, active-high.
- BTN_NEXT  input  1  raw asynchronous button; high = pressed.
- BTN_PREV  input  1  raw asynchronous button; high = pressed.
- color_idx  output  4  current palette index.
- rgb  output  12  current colour: {R[3:0], G[3:0], B[3:0]}; registered.
- changed  output  1  one-cycle pulse, asserted in the same cycle color_idx/rgb take a new value.

Behaviour:
- Reset: while RST is high at a clock edge:
  - color_idx=0, rgb=12'h000, changed=0.
  - Synchroniser flops, debounced levels and debounce/repeat counters all cleared to 0.
  - Reset has priority over every other event.
  - Reset mid-debounce discards the partial count. A button still held after reset must be re-qualified for a full DEBOUNCE_CYCLES before it is accepted.
- Synchroniser: two-flop chain per button.
- Debounce, per button:
  - Keep a stable level and a counter.
  - When synced level == stable level: counter cleared.
  - Otherwise the counter increments. On the cycle the counter would reach DEBOUNCE_CYCLES, stable takes the synced level and the counter clears.
  - Any glitch back to the stable level before that cycle restarts the count from 0.
- Edge detect: press pulse = stable rose this cycle (0->1). Releases produce no pulse.
- Index update (registered, one cycle after the press pulse):
  - next pulse only: idx = (idx==NCOLORS-1) ? 0 : idx+1.
  - prev pulse only: idx = (idx==0) ? NCOLORS-1 : idx-1.
  - Both pulses in the same cycle: no change, changed stays 0.
  - Neither pulse: hold.
- Latency: BTN held high from clock edge k, with no bounce, gives color_idx/rgb/changed updated at edge k+DEBOUNCE_CYCLES+3.
- rgb is a registered palette lookup of the new index, valid in the same cycle as color_idx.
- Palette, index:value:
  - 0:000, 1:F00, 2:0F0, 3:00F, 4:FF0, 5:0FF, 6:F0F, 7:FFF
  - 8:777, 9:700, 10:070, 11:007, 12:770, 13:077, 14:707, 15:333
- Counter widths: sized from the parameters; no counter saturates or overflows in legal ranges.

Optional Feature:
- Macro: VGA_COLOR_AUTO_REPEAT_EN.
- Defined:
  - While exactly one button's stable level stays high, a repeat counter runs.
  - Every REPEAT_CYCLES after the press step, an additional step in that direction is issued, with changed pulsing each time.
  - The counter clears on release, on both buttons being held, or on reset.
- Undefined:
  - The repeat counter and its logic are absent.
  - A held button yields exactly one step per press.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20):
1. RST high 3 cycles, then low -> color_idx=0, rgb=000, changed=0; no change for 50 idle cycles.
2. BTN_NEXT high from edge k, held -> at edge k+7: color_idx=1, rgb=F00, changed=1 for exactly 1 cycle. Release and repeat the press 7 more times -> index 7 (FFF), then wraps to 0 (000).
3. From idx 0, clean BTN_PREV press -> idx=NCOLORS-1=7, rgb=FFF. With NCOLORS=16 the same press gives idx 15, rgb=333.
4. BTN_NEXT bounce 1,0,1,0 each lasting 2 cycles, then steady 1 -> exactly one step; the update comes DEBOUNCE_CYCLES+3 edges after the final rising edge.
5. BTN_NEXT and BTN_PREV rising on the same edge, held -> idx unchanged, changed never asserted. Assert RST mid-debounce -> outputs reset; a still-held button steps once a full debounce later.
6. With VGA_COLOR_AUTO_REPEAT_EN, hold BTN_NEXT 70 cycles -> steps at k+7, k+27, k+47, k+67 (idx 1..4). Without the macro -> single step to idx 1.
